tlm_pair_scheduler: RTL
=======================

Name: tlm_pair_scheduler

Overview:
- Ping-pong batch scheduler between the DPI/TLM payload producer and the bfm A/B operand inputs.
- Producer writes batches of NUM operand pairs into one of two banks while the other bank streams one pair per handshake toward the bfm.
- Counts batches, requests new payloads when a bank frees, and stops after BATCH_NUM batches.
- Replaces the single-buffer xmit_en toggle with overlapped fill and drain.

Parameters:
- NUM, 1000: operand pairs per batch; bank depth.
- ITEM_WIDTH, 8: width of each operand.
- BATCH_NUM, 2000: batches to stream before DONE; 0 means run forever.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle start pulse, accepted in IDLE or DONE.
- wr_en_i  in  1  producer write strobe, one pair per cycle.
- wr_a_i  in  ITEM_WIDTH  operand A of the written pair.
- wr_b_i  in  ITEM_WIDTH  operand B of the written pair.
- wr_ready_o  out  1  write accepted this cycle if wr_en_i is high.
- batch_req_o  out  1  level; producer should supply another batch.
- a_o  out  ITEM_WIDTH  registered operand A to the bfm.
- b_o  out  ITEM_WIDTH  registered operand B to the bfm.
- valid_o  out  1  a_o/b_o hold a valid pair.
- ready_i  in  1  consumer accepts the pair.
- batch_done_o  out  1  one-cycle pulse on the last pair handshake of a batch.
- batch_cnt_o  out  32  completed batches since start.
- busy_o  out  1  FSM is not in IDLE or DONE.
- done_o  out  1  BATCH_NUM batches completed.

Behaviour:
- Reset (async, reset_n_i=0):
  - Outputs: a_o=0, b_o=0, valid_o=0, wr_ready_o=0, batch_req_o=0, batch_done_o=0, batch_cnt_o=0, busy_o=0, done_o=0.
  - Internal: full[1:0]=0, wr_bank=0, rd_bank=0, pointers=0, fill_cnt=0, FSM=IDLE.
  - Reset mid-operation discards all buffered data.
- Storage: two banks of NUM x (2*ITEM_WIDTH). Write side has wr_bank and wr_ptr; read side has rd_bank and rd_ptr.
- wr_ready_o = busy_o && !full[wr_bank] && (BATCH_NUM==0 || fill_cnt<BATCH_NUM).
- batch_req_o = wr_ready_o && wr_ptr==0.
- Write accepted when wr_en_i && wr_ready_o; the pair is stored at wr_ptr and wr_ptr increments.
  - On the NUM-th write: full[wr_bank]<=1, wr_bank toggles, wr_ptr<=0, fill_cnt++.
  - Writes while wr_ready_o=0 are dropped silently.
- FSM states: IDLE, WAIT, STREAM, DONE.
  - IDLE: start_i -> WAIT.
  - WAIT: full[rd_bank] -> STREAM; same edge loads the pair at rd_ptr=0 into a_o/b_o and sets valid_o=1. valid_o therefore rises one edge after the edge that set full.
  - STREAM: a_o/b_o/valid_o stay stable while valid_o && !ready_i. On a handshake that is not the last pair, rd_ptr++ and the next pair loads with no bubble.
  - STREAM, last-pair handshake:
    - full[rd_bank]<=0, rd_bank toggles, rd_ptr<=0, batch_cnt_o++, batch_done_o pulses.
    - If batch_cnt_o+1==BATCH_NUM (BATCH_NUM!=0): go to DONE with valid_o=0.
    - Else if full[other bank]: load its pair 0 with no bubble and stay in STREAM.
    - Else: valid_o=0 and go to WAIT.
  - DONE: done_o=1, wr_ready_o=0, valid_o=0. start_i clears counters, pointers and full flags, then goes to WAIT.
- start_i in WAIT or STREAM is ignored.
- Simultaneous events:
  - Fill completes on one bank in the same edge a drain frees the other: both updates apply.
  - A single bank cannot be filled and drained at once, because full gates both sides.
- batch_cnt_o saturates at 2^32-1 when BATCH_NUM==0.

Optional Feature:
- Macro TLM_SCHED_CHECKSUM_EN.
- Defined:
  - Adds ports checksum_o (32) and checksum_valid_o (1).
  - Accumulates the zero-extended sum a_o+b_o over every handshake of the batch, modulo 2^32.
  - On batch_done_o: checksum_o is set to the batch total and checksum_valid_o pulses in the same cycle; the accumulator clears for the next batch.
  - Reset and restart clear both.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- NUM=4, BATCH_NUM=3, ready_i=1; start, then write pairs (1,2),(3,4),(5,6),(7,8) -> valid_o rises one edge after the 4th write; a_o/b_o show 1/2, 3/4, 5/6, 7/8 on consecutive cycles; batch_done_o pulses once; batch_cnt_o=1.
- Preload both banks (8 writes) before ready_i=1 -> wr_ready_o=0 after the 8th write; 8 consecutive handshakes with no valid_o gap between batches.
- ready_i toggles 1,0,0,1 during STREAM -> a_o/b_o held stable while ready_i=0; no pair lost or repeated.
- Run 3 batches -> done_o=1, valid_o=0, wr_ready_o=0; further wr_en_i is ignored; start_i restarts with batch_cnt_o=0.
- Drive reset_n_i low after 2 pairs of batch 1 -> all outputs return to reset values immediately; after release and start_i, the first valid pair comes only from newly written data.
- With TLM_SCHED_CHECKSUM_EN defined, pairs (255,255),(1,0),(0,0),(10,20) -> checksum_o=541, checksum_valid_o high in the batch_done_o cycle.

Source files
------------

// File: rtl/tlm_pair_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : tlm_pair_scheduler_if
// Description : Bundle of the producer write port, the bfm operand stream
//               and the status outputs of tlm_pair_scheduler.
//               slave  modport : the scheduler itself.
//               master modport : producer / bfm / controller side.
//               Optional macro TLM_SCHED_CHECKSUM_EN adds checksum_o and
//               checksum_valid_o.
// Revision    : 1.0 - initial release
// ============================================================================
interface tlm_pair_scheduler_if #(
    parameter int ITEM_WIDTH = 8
);
    // control
    logic                  start_i;
    // producer side
    logic                  wr_en_i;
    logic [ITEM_WIDTH-1:0] wr_a_i;
    logic [ITEM_WIDTH-1:0] wr_b_i;
    logic                  wr_ready_o;
    logic                  batch_req_o;
    // bfm side
    logic [ITEM_WIDTH-1:0] a_o;
    logic [ITEM_WIDTH-1:0] b_o;
    logic                  valid_o;
    logic                  ready_i;
    // status
    logic                  batch_done_o;
    logic [31:0]           batch_cnt_o;
    logic                  busy_o;
    logic                  done_o;
`ifdef TLM_SCHED_CHECKSUM_EN
    logic [31:0]           checksum_o;
    logic                  checksum_valid_o;

    modport slave (
        input  start_i, wr_en_i, wr_a_i, wr_b_i, ready_i,
        output wr_ready_o, batch_req_o, a_o, b_o, valid_o,
               batch_done_o, batch_cnt_o, busy_o, done_o,
               checksum_o, checksum_valid_o
    );

    modport master (
        output start_i, wr_en_i, wr_a_i, wr_b_i, ready_i,
        input  wr_ready_o, batch_req_o, a_o, b_o, valid_o,
               batch_done_o, batch_cnt_o, busy_o, done_o,
               checksum_o, checksum_valid_o
    );
`else
    modport slave (
        input  start_i, wr_en_i, wr_a_i, wr_b_i, ready_i,
        output wr_ready_o, batch_req_o, a_o, b_o, valid_o,
               batch_done_o, batch_cnt_o, busy_o, done_o
    );

    modport master (
        output start_i, wr_en_i, wr_a_i, wr_b_i, ready_i,
        input  wr_ready_o, batch_req_o, a_o, b_o, valid_o,
               batch_done_o, batch_cnt_o, busy_o, done_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/tlm_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tlm_pair_scheduler
// Description : Ping-pong batch scheduler. The producer fills one bank with
//               NUM operand pairs while the other bank streams one pair per
//               ready/valid handshake to the bfm A/B inputs. Stops after
//               BATCH_NUM batches (0 = run forever).
// Ports       : clk_i      - clock
//               reset_n_i  - asynchronous active-low reset
//               bus        - tlm_pair_scheduler_if.slave (start, producer
//                            write port, operand stream, status)
// Options     : TLM_SCHED_CHECKSUM_EN - adds per-batch sum of a_o+b_o on
//               checksum_o with checksum_valid_o pulsing on batch_done_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tlm_pair_scheduler #(
    parameter int NUM        = 1000,
    parameter int ITEM_WIDTH = 8,
    parameter int BATCH_NUM  = 2000
) (
    input  wire logic              clk_i,
    input  wire logic              reset_n_i,
    tlm_pair_scheduler_if.slave    bus
);

    localparam int                 c_PTR_W     = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(NUM - 1);
    localparam logic [31:0]        c_BATCH_NUM = 32'(BATCH_NUM);
    localparam logic [31:0]        c_CNT_MAX   = 32'hFFFF_FFFF;
    localparam int                 c_PAIR_W    = 2 * ITEM_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [c_PAIR_W-1:0]     r_mem [0:1][0:NUM-1];
    logic [1:0]              r_full;
    logic                    r_wr_bank;
    logic                    r_rd_bank;
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [31:0]             r_fill_cnt;
    logic [31:0]             r_batch_cnt;
    logic [ITEM_WIDTH-1:0]   r_a;
    logic [ITEM_WIDTH-1:0]   r_b;
    logic                    r_valid;
    logic                    r_batch_done;
    logic                    r_done;

    logic                    w_busy;
    logic                    w_fill_room;
    logic                    w_wr_ready;
    logic                    w_wr_fire;
    logic                    w_hs;
    logic                    w_rd_last;
    logic                    w_final;
    logic                    w_restart;
    logic [c_PTR_W-1:0]      w_rd_ptr_nxt;
    logic [c_PAIR_W-1:0]     w_next_pair;
    logic [c_PAIR_W-1:0]     w_head_same;
    logic [c_PAIR_W-1:0]     w_head_other;

    assign w_busy       = (r_state == S_WAIT) || (r_state == S_STREAM);
    // Once BATCH_NUM batches have been filled no further writes are taken,
    // even if a bank is free.
    assign w_fill_room  = (c_BATCH_NUM == 32'd0) || (r_fill_cnt < c_BATCH_NUM);
    assign w_wr_ready   = w_busy && !r_full[r_wr_bank] && w_fill_room;
    assign w_wr_fire    = bus.wr_en_i && w_wr_ready;
    assign w_hs         = (r_state == S_STREAM) && r_valid && bus.ready_i;
    assign w_rd_last    = w_hs && (r_rd_ptr == c_LAST_PTR);
    assign w_final      = w_rd_last && (c_BATCH_NUM != 32'd0) &&
                          ((r_batch_cnt + 32'd1) == c_BATCH_NUM);
    assign w_restart    = bus.start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(1);
    assign w_next_pair  = r_mem[r_rd_bank][w_rd_ptr_nxt];
    assign w_head_same  = r_mem[r_rd_bank][0];
    assign w_head_other = r_mem[~r_rd_bank][0];

    // Bank storage: no reset, the full flags alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (w_wr_fire) begin
            r_mem[r_wr_bank][r_wr_ptr] <= {bus.wr_a_i, bus.wr_b_i};
        end
    end

    // Control FSM together with write-side bookkeeping; both sides touch the
    // full flags so they live in one process. The full flag of a bank gates
    // both its writer and its reader, so a set and a clear in the same cycle
    // always address different bits.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= S_IDLE;
            r_full       <= 2'b00;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill_cnt   <= 32'd0;
            r_batch_cnt  <= 32'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_valid      <= 1'b0;
            r_batch_done <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_batch_done <= 1'b0;
            if (w_restart) begin
                r_state     <= S_WAIT;
                r_full      <= 2'b00;
                r_wr_bank   <= 1'b0;
                r_rd_bank   <= 1'b0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_fill_cnt  <= 32'd0;
                r_batch_cnt <= 32'd0;
                r_valid     <= 1'b0;
                r_done      <= 1'b0;
            end else begin
                // write side
                if (w_wr_fire) begin
                    if (r_wr_ptr == c_LAST_PTR) begin
                        r_full[r_wr_bank] <= 1'b1;
                        r_wr_bank         <= ~r_wr_bank;
                        r_wr_ptr          <= '0;
                        if (r_fill_cnt != c_CNT_MAX) begin
                            r_fill_cnt <= r_fill_cnt + 32'd1;
                        end
                    end else begin
                        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                    end
                end

                // read side
                case (r_state)
                    S_IDLE: begin
                        r_valid <= 1'b0;
                    end
                    S_WAIT: begin
                        if (r_full[r_rd_bank]) begin
                            r_a     <= w_head_same[c_PAIR_W-1:ITEM_WIDTH];
                            r_b     <= w_head_same[ITEM_WIDTH-1:0];
                            r_valid <= 1'b1;
                            r_state <= S_STREAM;
                        end
                    end
                    S_STREAM: begin
                        if (w_rd_last) begin
                            r_full[r_rd_bank] <= 1'b0;
                            r_rd_bank         <= ~r_rd_bank;
                            r_rd_ptr          <= '0;
                            r_batch_done      <= 1'b1;
                            if (r_batch_cnt != c_CNT_MAX) begin
                                r_batch_cnt <= r_batch_cnt + 32'd1;
                            end
                            if (w_final) begin
                                r_valid <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else if (r_full[~r_rd_bank]) begin
                                // other bank already waiting: no bubble
                                r_a <= w_head_other[c_PAIR_W-1:ITEM_WIDTH];
                                r_b <= w_head_other[ITEM_WIDTH-1:0];
                            end else begin
                                r_valid <= 1'b0;
                                r_state <= S_WAIT;
                            end
                        end else if (w_hs) begin
                            r_rd_ptr <= w_rd_ptr_nxt;
                            r_a      <= w_next_pair[c_PAIR_W-1:ITEM_WIDTH];
                            r_b      <= w_next_pair[ITEM_WIDTH-1:0];
                        end
                    end
                    S_DONE: begin
                        r_valid <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.wr_ready_o   = w_wr_ready;
    assign bus.batch_req_o  = w_wr_ready && (r_wr_ptr == '0);
    assign bus.a_o          = r_a;
    assign bus.b_o          = r_b;
    assign bus.valid_o      = r_valid;
    assign bus.batch_done_o = r_batch_done;
    assign bus.batch_cnt_o  = r_batch_cnt;
    assign bus.busy_o       = w_busy;
    assign bus.done_o       = r_done;

`ifdef TLM_SCHED_CHECKSUM_EN
    logic [31:0] r_acc;
    logic [31:0] r_checksum;
    logic        r_checksum_valid;
    logic [31:0] w_acc_sum;

    // running sum including the pair being handshaken this cycle
    assign w_acc_sum = r_acc + 32'(r_a) + 32'(r_b);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_acc            <= 32'd0;
            r_checksum       <= 32'd0;
            r_checksum_valid <= 1'b0;
        end else if (w_restart) begin
            r_acc            <= 32'd0;
            r_checksum       <= 32'd0;
            r_checksum_valid <= 1'b0;
        end else if (w_rd_last) begin
            r_acc            <= 32'd0;
            r_checksum       <= w_acc_sum;
            r_checksum_valid <= 1'b1;
        end else begin
            r_checksum_valid <= 1'b0;
            if (w_hs) begin
                r_acc <= w_acc_sum;
            end
        end
    end

    assign bus.checksum_o       = r_checksum;
    assign bus.checksum_valid_o = r_checksum_valid;
`endif

endmodule
`default_nettype wire
